// File: rtl/game_score_ctrl.sv
// rtl/game_score_ctrl.sv - score keeping and serve sequencing FSM for a two-player paddle game
module game_score_ctrl #(
    parameter int          WIN_SCORE    = 11,
    parameter int unsigned SERVE_CYCLES = 65_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_hold,
    output logic       serve_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_OVER
    } state_t;

    localparam logic [31:0] SERVE_LAST = 32'(SERVE_CYCLES - 32'd1);
    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        start_prev_q, miss_l_prev_q, miss_r_prev_q;
    logic        ball_hold_q, ball_hold_d;
    logic        serve_dir_q, serve_dir_d;
    logic [3:0]  score_left_q, score_left_d;
    logic [3:0]  score_right_q, score_right_d;
    logic        game_over_q, game_over_d;
    logic        winner_q, winner_d;
    logic [3:0]  next_left, next_right;

    logic rise_start, rise_miss_l, rise_miss_r;

    assign rise_start  = start & ~start_prev_q;
    assign rise_miss_l = miss_left & ~miss_l_prev_q;
    assign rise_miss_r = miss_right & ~miss_r_prev_q;

    assign next_left  = score_left_q + 4'd1;
    assign next_right = score_right_q + 4'd1;

    // Next-state and next-output logic; every output is a flop fed from here.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        serve_dir_d   = serve_dir_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        game_over_d   = game_over_q;
        winner_d      = winner_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rise_start) begin
                    score_left_d  = '0;
                    score_right_d = '0;
                    state_d       = S_SERVE;
                end
            end
            S_SERVE: begin
                if (cnt_q == SERVE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_PLAY;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_PLAY: begin
                cnt_d = '0;
                if (rise_miss_l && rise_miss_r) begin
                    // Simultaneous misses are a replay: nobody scores.
                    state_d = S_SERVE;
                end else if (rise_miss_l) begin
                    score_right_d = next_right;
                    serve_dir_d   = 1'b0;
                    if (next_right == WIN) begin
                        state_d     = S_OVER;
                        game_over_d = 1'b1;
                        winner_d    = 1'b1;
                    end else begin
                        state_d = S_SERVE;
                    end
                end else if (rise_miss_r) begin
                    score_left_d = next_left;
                    serve_dir_d  = 1'b1;
                    if (next_left == WIN) begin
                        state_d     = S_OVER;
                        game_over_d = 1'b1;
                        winner_d    = 1'b0;
                    end else begin
                        state_d = S_SERVE;
                    end
                end
            end
            S_OVER: begin
                cnt_d = '0;
                if (rise_start) begin
                    score_left_d  = '0;
                    score_right_d = '0;
                    game_over_d   = 1'b0;
                    state_d       = S_SERVE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // The ball only moves while playing; registering this keeps it aligned with the state.
        ball_hold_d = (state_d != S_PLAY);
    end

    // State, counter, edge-history and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            start_prev_q  <= 1'b0;
            miss_l_prev_q <= 1'b0;
            miss_r_prev_q <= 1'b0;
            ball_hold_q   <= 1'b1;
            serve_dir_q   <= 1'b1;
            score_left_q  <= '0;
            score_right_q <= '0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            start_prev_q  <= start;
            miss_l_prev_q <= miss_left;
            miss_r_prev_q <= miss_right;
            ball_hold_q   <= ball_hold_d;
            serve_dir_q   <= serve_dir_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
        end
    end

    assign ball_hold   = ball_hold_q;
    assign serve_dir   = serve_dir_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_game_score_ctrl.sv
// tb/tb_game_score_ctrl.sv - self-checking bench for game_score_ctrl
module tb_game_score_ctrl;

    localparam int WIN   = 3;
    localparam int SERVE = 4;

    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_PLAY  = 2;
    localparam int P_OVER  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       ball_hold;
    logic       serve_dir;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;
    logic       winner;
    logic [11:0] dut_vec;

    int n_pass = 0;
    int n_total = 0;

    int m_phase = P_IDLE;
    int m_wait = 0;
    int m_sl = 0;
    int m_sr = 0;
    bit m_dir = 1'b1;
    bit m_win = 1'b0;
    bit m_ps = 1'b0;
    bit m_pl = 1'b0;
    bit m_pr = 1'b0;

    game_score_ctrl #(
        .WIN_SCORE   (WIN),
        .SERVE_CYCLES(SERVE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .ball_hold  (ball_hold),
        .serve_dir  (serve_dir),
        .score_left (score_left),
        .score_right(score_right),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    assign dut_vec = {ball_hold, serve_dir, score_left, score_right, game_over, winner};

    function automatic logic [11:0] model_vec();
        logic hold;
        logic over;
        hold = (m_phase != P_PLAY);
        over = (m_phase == P_OVER);
        return {hold, logic'(m_dir), 4'(m_sl), 4'(m_sr), over, logic'(m_win)};
    endfunction

    task automatic go_serve();
        m_phase = P_SERVE;
        m_wait  = SERVE;
    endtask

    // Game rules: one point per fresh miss during play, first to WIN ends the game.
    task automatic model_update(input bit s, input bit ml, input bit mr, input bit r);
        bit rs, rl, rr;
        if (r) begin
            m_phase = P_IDLE; m_wait = 0; m_sl = 0; m_sr = 0;
            m_dir = 1'b1; m_win = 1'b0; m_ps = 1'b0; m_pl = 1'b0; m_pr = 1'b0;
            return;
        end
        rs = s && !m_ps;
        rl = ml && !m_pl;
        rr = mr && !m_pr;
        m_ps = s; m_pl = ml; m_pr = mr;
        case (m_phase)
            P_IDLE: if (rs) begin m_sl = 0; m_sr = 0; go_serve(); end
            P_SERVE: begin
                m_wait--;
                if (m_wait == 0) m_phase = P_PLAY;
            end
            P_PLAY: begin
                if (rl && rr) go_serve();
                else if (rl) begin
                    m_sr++; m_dir = 1'b0;
                    if (m_sr == WIN) begin m_phase = P_OVER; m_win = 1'b1; end
                    else go_serve();
                end else if (rr) begin
                    m_sl++; m_dir = 1'b1;
                    if (m_sl == WIN) begin m_phase = P_OVER; m_win = 1'b0; end
                    else go_serve();
                end
            end
            default: if (rs) begin m_sl = 0; m_sr = 0; go_serve(); end
        endcase
    endtask

    task automatic step(input bit s, input bit ml, input bit mr, input bit r);
        start = s; miss_left = ml; miss_right = mr; rst = r;
        @(posedge clk);
        model_update(s, ml, mr, r);
        #1;
    endtask

    task automatic wait_play(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ball_hold === 1'b0) begin ok = 1'b1; break; end
            step(0, 0, 0, 0);
        end
    endtask

    task automatic test_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        n_total++;
        if (dut_vec !== 12'b1_1_0000_0000_0_0) $display("FAIL reset_values: got %b want %b", dut_vec, 12'b1_1_0000_0000_0_0);
        else n_pass++;
        step(0, 0, 0, 0);
        n_total++;
        if (dut_vec !== model_vec()) $display("FAIL reset_idle: got %b want %b", dut_vec, model_vec());
        else n_pass++;
    endtask

    task automatic test_serve();
        int hold;
        step(1, 0, 0, 0);
        hold = 0;
        for (int i = 0; i < 20; i++) begin
            if (ball_hold !== 1'b1) break;
            hold++;
            step(0, 0, 0, 0);
        end
        n_total++;
        if (hold != SERVE) $display("FAIL serve_hold_len: got %0d want %0d", hold, SERVE);
        else n_pass++;
        n_total++;
        if ({score_left, score_right} !== 8'h00) $display("FAIL serve_scores: got %h want 00", {score_left, score_right});
        else n_pass++;
        n_total++;
        if (dut_vec !== model_vec()) $display("FAIL serve_model: got %b want %b", dut_vec, model_vec());
        else n_pass++;
    endtask

    task automatic test_point_held();
        step(0, 0, 1, 0);
        n_total++;
        if ({score_left, serve_dir, ball_hold} !== {4'd1, 1'b1, 1'b1})
            $display("FAIL held_point: got sl=%0d dir=%b hold=%b want sl=1 dir=1 hold=1", score_left, serve_dir, ball_hold);
        else n_pass++;
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        n_total++;
        if (ball_hold !== 1'b0) $display("FAIL held_release: got hold=%b want 0", ball_hold);
        else n_pass++;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        n_total++;
        if ({score_left, score_right, ball_hold} !== {4'd1, 4'd0, 1'b0})
            $display("FAIL held_once: got sl=%0d sr=%0d hold=%b want 1 0 0", score_left, score_right, ball_hold);
        else n_pass++;
        n_total++;
        if (dut_vec !== model_vec()) $display("FAIL held_model: got %b want %b", dut_vec, model_vec());
        else n_pass++;
    endtask

    task automatic test_simul();
        bit ok;
        step(0, 1, 1, 0);
        n_total++;
        if ({score_left, score_right, serve_dir, ball_hold} !== {4'd1, 4'd0, 1'b1, 1'b1})
            $display("FAIL simul_replay: got sl=%0d sr=%0d dir=%b hold=%b want 1 0 1 1", score_left, score_right, serve_dir, ball_hold);
        else n_pass++;
        step(0, 0, 0, 0);
        wait_play(ok);
        n_total++;
        if (!ok) $display("FAIL simul_timeout: got no play want play");
        else n_pass++;
    endtask

    task automatic test_win();
        bit ok;
        for (int k = 1; k <= 3; k++) begin
            step(0, 1, 0, 0);
            step(0, 0, 0, 0);
            n_total++;
            if (score_right !== 4'(k)) $display("FAIL win_count%0d: got %0d want %0d", k, score_right, k);
            else n_pass++;
            if (k < 3) begin
                wait_play(ok);
                n_total++;
                if (!ok) $display("FAIL win_timeout%0d: got no play want play", k);
                else n_pass++;
            end
        end
        n_total++;
        if ({game_over, winner, ball_hold} !== 3'b111) $display("FAIL win_over: got %b want 111", {game_over, winner, ball_hold});
        else n_pass++;
        for (int i = 0; i < 2; i++) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
        n_total++;
        if ({score_right, game_over} !== {4'd3, 1'b1}) $display("FAIL win_frozen: got sr=%0d go=%b want 3 1", score_right, game_over);
        else n_pass++;
        step(1, 0, 0, 0);
        n_total++;
        if ({score_left, score_right, game_over, ball_hold} !== {8'h00, 1'b0, 1'b1})
            $display("FAIL win_restart: got sl=%0d sr=%0d go=%b hold=%b want 0 0 0 1", score_left, score_right, game_over, ball_hold);
        else n_pass++;
        step(0, 0, 0, 0);
        n_total++;
        if (dut_vec !== model_vec()) $display("FAIL win_model: got %b want %b", dut_vec, model_vec());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        for (int i = 0; i < 2; i++) begin
            wait_play(ok);
            step(0, 0, 1, 0);
            step(0, 0, 0, 0);
        end
        wait_play(ok);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        n_total++;
        if ({score_left, score_right, ball_hold} !== {4'd2, 4'd1, 1'b1})
            $display("FAIL rmid_setup: got sl=%0d sr=%0d hold=%b want 2 1 1", score_left, score_right, ball_hold);
        else n_pass++;
        step(0, 0, 0, 1);
        n_total++;
        if (dut_vec !== 12'b1_1_0000_0000_0_0) $display("FAIL rmid_reset: got %b want %b", dut_vec, 12'b1_1_0000_0000_0_0);
        else n_pass++;
        for (int i = 0; i < 8; i++) step(0, i[0], i[1], 0);
        n_total++;
        if ({ball_hold, score_left, score_right, game_over} !== {1'b1, 8'h00, 1'b0})
            $display("FAIL rmid_idle: got hold=%b sl=%0d sr=%0d go=%b want 1 0 0 0", ball_hold, score_left, score_right, game_over);
        else n_pass++;
    endtask

    task automatic test_ignore();
        bit ok;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        wait_play(ok);
        step(1, 0, 0, 0);
        n_total++;
        if ({ball_hold, score_left, score_right} !== {1'b0, 8'h00})
            $display("FAIL ign_start: got hold=%b sl=%0d sr=%0d want 0 0 0", ball_hold, score_left, score_right);
        else n_pass++;
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        n_total++;
        if ({ball_hold, score_left, score_right, serve_dir} !== {1'b1, 4'd1, 4'd0, 1'b1})
            $display("FAIL ign_miss: got hold=%b sl=%0d sr=%0d dir=%b want 1 1 0 1", ball_hold, score_left, score_right, serve_dir);
        else n_pass++;
        step(0, 0, 0, 0);
        n_total++;
        if (dut_vec !== model_vec()) $display("FAIL ign_model: got %b want %b", dut_vec, model_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        bit s, ml, mr, r;
        step(0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            s  = ($urandom_range(0, 30) == 0);
            ml = ($urandom_range(0, 5) == 0);
            mr = ($urandom_range(0, 5) == 0);
            r  = ($urandom_range(0, 400) == 0);
            step(s, ml, mr, r);
            n_total++;
            if (dut_vec !== model_vec()) $display("FAIL random_cycle%0d: got %b want %b", i, dut_vec, model_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_point_held();
        test_simul();
        test_win();
        test_reset_mid();
        test_ignore();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
